// File: rtl/rhd_spi_responder_if.sv
// SPI pins and frame status between the RHD acquisition master and the
// emulated headstage.
interface rhd_spi_responder_if;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic        frame_err;

  modport master (
    output cs_n, sclk, mosi,
    input  miso, cmd_valid, cmd_word, frame_err
  );

  modport slave (
    input  cs_n, sclk, mosi,
    output miso, cmd_valid, cmd_word, frame_err
  );
endinterface

// File: rtl/rhd_spi_responder.sv
// RHD2000-style SPI chip emulator: 16-bit frames, 2-frame result pipeline.
// Define RHD_RESP_ROM_EN to expose the read-only ID registers 40..63.
module rhd_spi_responder #(
  parameter int          SYNC_STAGES  = 2,
  parameter int unsigned NUM_CHANNELS = 32,
  parameter logic [7:0]  CHIP_ID      = 8'd1
) (
  input logic          aclk,
  input logic          aresetn,
  rhd_spi_responder_if.slave spi
);

`ifdef RHD_RESP_ROM_EN
  localparam bit ROM_EN = 1'b1;
`else
  localparam bit ROM_EN = 1'b0;
`endif

  localparam logic [5:0] NUM_RW = 6'd40;
  localparam logic [7:0] NCH8   = 8'(NUM_CHANNELS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] cs_s;
  logic [SYNC_STAGES-1:0] sclk_s;
  logic [SYNC_STAGES-1:0] mosi_s;
  logic cs_q;
  logic sclk_q;

  logic cs_now;
  logic sclk_now;
  logic mosi_now;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  state_t state;
  state_t state_nx;

  logic load;
  logic cap;
  logic sh;
  logic exec;
  logic abort;

  logic [4:0]  bit_cnt;
  logic [15:0] rx_sr;
  logic [14:0] tx_sr;
  logic        miso_q;
  logic [15:0] pipe0;
  logic [15:0] pipe1;
  logic [9:0]  frame_cnt;
  logic        cmd_valid_q;
  logic [15:0] cmd_word_q;
  logic        frame_err_q;
  logic [7:0]  regs [40];

  logic [5:0]  addr;
  logic [7:0]  rom_byte;
  logic [7:0]  rd_data;
  logic [15:0] result;
  logic        fc_inc;
  logic        wr_en;

  // cs_n idles high, so its chain resets to 1 to avoid a false frame start
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cs_s   <= '1;
      sclk_s <= '0;
      mosi_s <= '0;
      cs_q   <= 1'b1;
      sclk_q <= 1'b0;
    end else begin
      cs_s   <= {cs_s[SYNC_STAGES-2:0], spi.cs_n};
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], spi.sclk};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi.mosi};
      cs_q   <= cs_s[SYNC_STAGES-1];
      sclk_q <= sclk_s[SYNC_STAGES-1];
    end
  end

  assign cs_now    = cs_s[SYNC_STAGES-1];
  assign sclk_now  = sclk_s[SYNC_STAGES-1];
  assign mosi_now  = mosi_s[SYNC_STAGES-1];
  assign sclk_rise = sclk_now & ~sclk_q;
  assign sclk_fall = ~sclk_now & sclk_q;
  assign cs_fall   = ~cs_now & cs_q;
  assign cs_rise   = cs_now & ~cs_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cs_fall) state_nx = SHIFT;
      SHIFT:   if (cs_rise) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    cap   = 1'b0;
    sh    = 1'b0;
    exec  = 1'b0;
    abort = 1'b0;
    unique case (state)
      IDLE:  load = cs_fall;
      SHIFT: begin
        cap = sclk_rise;
        sh  = sclk_fall;
      end
      DONE: begin
        exec  = (bit_cnt == 5'd16);
        abort = (bit_cnt != 5'd16);
      end
      default: ;
    endcase
  end

  assign addr = rx_sr[13:8];

  always_comb begin
    rom_byte = '0;
    case (addr)
      6'd40:   rom_byte = 8'h49;
      6'd41:   rom_byte = 8'h4E;
      6'd42:   rom_byte = 8'h54;
      6'd43:   rom_byte = 8'h41;
      6'd44:   rom_byte = 8'h4E;
      6'd60:   rom_byte = 8'h01;
      6'd62:   rom_byte = NCH8;
      6'd63:   rom_byte = CHIP_ID;
      default: rom_byte = '0;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (addr < NUM_RW) rd_data = regs[addr];
    else if (ROM_EN)   rd_data = rom_byte;
  end

  // CALIBRATE, CLEAR and any other 01 word all just return zero
  always_comb begin
    result = '0;
    fc_inc = 1'b0;
    wr_en  = 1'b0;
    unique case (rx_sr[15:14])
      2'b00: begin
        fc_inc = 1'b1;
        if ({26'd0, addr} < NUM_CHANNELS)
          result = {addr, frame_cnt};
      end
      2'b01: result = '0;
      2'b10: begin
        wr_en  = (addr < NUM_RW);
        result = {8'hFF, rx_sr[7:0]};
      end
      2'b11: result = {8'h00, rd_data};
      default: result = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      miso_q  <= 1'b0;
    end else begin
      if (load) begin
        bit_cnt <= '0;
        tx_sr   <= pipe1[14:0];
        miso_q  <= pipe1[15];
      end
      // saturate so an over-long frame can never wrap back to 16
      if (cap) begin
        rx_sr <= {rx_sr[14:0], mosi_now};
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end
      if (sh) begin
        tx_sr  <= {tx_sr[13:0], 1'b0};
        miso_q <= tx_sr[14];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pipe0       <= '0;
      pipe1       <= '0;
      frame_cnt   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_word_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cmd_valid_q <= exec;
      frame_err_q <= abort;
      if (exec) begin
        cmd_word_q <= rx_sr;
        pipe1      <= pipe0;
        pipe0      <= result;
        if (fc_inc) frame_cnt <= frame_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 40; i++) regs[i] <= '0;
    end else if (exec && wr_en) begin
      regs[addr] <= rx_sr[7:0];
    end
  end

  assign spi.miso      = miso_q;
  assign spi.cmd_valid = cmd_valid_q;
  assign spi.cmd_word  = cmd_word_q;
  assign spi.frame_err = frame_err_q;

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Directed bench for rhd_spi_responder: SPI master tasks, reference model
// and a queue of expected MISO words.
`timescale 1ns/1ps
module tb_rhd_spi_responder;
  localparam int         S   = 2;
  localparam int         NC  = 32;
  localparam logic [7:0] CID = 8'd1;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  rhd_spi_responder_if spi ();

  rhd_spi_responder #(
    .SYNC_STAGES (S),
    .NUM_CHANNELS(NC),
    .CHIP_ID     (CID)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .spi    (spi)
  );

  int errors = 0;
  int checks = 0;
  int nvalid = 0;
  int nerr   = 0;
  logic [15:0] last_cmd = '0;

  logic [15:0] exp_q [$];
  logic [15:0] mp0;
  logic [15:0] mp1;
  logic [9:0]  mfc;
  logic [7:0]  mreg [40];

  always @(negedge aclk) begin
    if (spi.cmd_valid) begin
      nvalid   = nvalid + 1;
      last_cmd = spi.cmd_word;
    end
    if (spi.frame_err) nerr = nerr + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge aclk);
  endtask

  function automatic logic [7:0] mread(input logic [5:0] a);
    if (a < 40) return mreg[a];
`ifdef RHD_RESP_ROM_EN
    case (a)
      6'd40: return 8'h49;
      6'd41: return 8'h4E;
      6'd42: return 8'h54;
      6'd43: return 8'h41;
      6'd44: return 8'h4E;
      6'd60: return 8'h01;
      6'd62: return 8'(NC);
      6'd63: return CID;
      default: return 8'h00;
    endcase
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_reset();
    mp0 = '0;
    mp1 = '0;
    mfc = '0;
    for (int i = 0; i < 40; i++) mreg[i] = '0;
    exp_q.delete();
  endtask

  task automatic model_exec(input logic [15:0] w);
    logic [15:0] res;
    logic [5:0]  a;
    a = w[13:8];
    case (w[15:14])
      2'b00: begin
        res = (int'(a) < NC) ? {a, mfc} : 16'h0000;
        mfc = mfc + 10'd1;
      end
      2'b01: res = 16'h0000;
      2'b10: begin
        if (a < 40) mreg[a] = w[7:0];
        res = {8'hFF, w[7:0]};
      end
      default: res = {8'h00, mread(a)};
    endcase
    mp1 = mp0;
    mp0 = res;
  endtask

  task automatic do_reset();
    spi.cs_n = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    aresetn  = 1'b0;
    cyc(3);
    aresetn = 1'b1;
    cyc(4);
    model_reset();
  endtask

  // master samples MISO just before each SCLK fall
  task automatic spi_frame(input logic [15:0] w, input int nbits,
                           output logic [15:0] rx);
    rx = '0;
    spi.cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi.mosi = w[15-i];
      cyc(2);
      spi.sclk = 1'b1;
      cyc(2);
      rx = {rx[14:0], spi.miso};
      spi.sclk = 1'b0;
    end
    cyc(1);
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
    cyc(6);
  endtask

  task automatic send(input logic [15:0] w, output logic [15:0] rx);
    int v0;
    int e0;
    logic [15:0] exp;
    v0 = nvalid;
    e0 = nerr;
    exp_q.push_back(mp1);
    spi_frame(w, 16, rx);
    exp = exp_q.pop_front();
    chk("miso_word", rx, exp);
    chk("cmd_valid_pulses", 16'(nvalid - v0), 16'd1);
    chk("frame_err_pulses", 16'(nerr - e0), 16'd0);
    chk("cmd_word", last_cmd, w);
    model_exec(w);
  endtask

  task automatic abort_frame(input logic [15:0] w, input int nbits);
    int v0;
    int e0;
    logic [15:0] rx;
    v0 = nvalid;
    e0 = nerr;
    spi_frame(w, nbits, rx);
    chk("abort_frame_err", 16'(nerr - e0), 16'd1);
    chk("abort_cmd_valid", 16'(nvalid - v0), 16'd0);
  endtask

  logic [15:0] rx;
  logic [15:0] rxs [10];
  logic [15:0] exp_id;
  logic [15:0] cmd_list [12];

  initial begin
    spi.cs_n = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    do_reset();

    chk("reset_miso", {15'd0, spi.miso}, 16'd0);
    chk("reset_cmd_valid", {15'd0, spi.cmd_valid}, 16'd0);
    chk("reset_frame_err", {15'd0, spi.frame_err}, 16'd0);
    chk("reset_cmd_word", spi.cmd_word, 16'd0);

`ifdef RHD_RESP_ROM_EN
    exp_id = 16'h0001;
`else
    exp_id = 16'h0000;
`endif
    send(16'hFF00, rx);
    chk("first_return_zero", rx, 16'h0000);
    send(16'h0000, rx);
    chk("second_return_zero", rx, 16'h0000);
    send(16'h0000, rx);
    chk("read_chip_id", rx, exp_id);

    send(16'h85A3, rx);
    send(16'hC500, rx);
    send(16'h0000, rx);
    chk("write5_echo", rx, 16'hFFA3);
    send(16'h0000, rx);
    chk("read5_data", rx, 16'h00A3);

    cmd_list = '{16'hA812, 16'hE800, 16'h5500, 16'h6A00,
                 16'h7FFF, 16'h2000, 16'h3F00, 16'hEC00,
                 16'hFE00, 16'hE700, 16'hC000, 16'hC000};
    foreach (cmd_list[i]) send(cmd_list[i], rx);

    send(16'h873C, rx);
    send(16'hC700, rx);
    abort_frame(16'h5555, 9);
    send(16'hC000, rx);
    chk("post_abort_pipe1", rx, 16'hFF3C);
    send(16'hC000, rx);
    chk("post_abort_pipe0", rx, 16'h003C);

    do_reset();
    for (int c = 0; c < 8; c++) send({2'b00, 6'(c), 8'h00}, rxs[c]);
    send(16'hC000, rxs[8]);
    send(16'hC000, rxs[9]);
    for (int c = 0; c < 8; c++)
      chk("convert_seq", rxs[c+2], 16'((c << 10) | c));

    send(16'h8277, rx);
    send(16'hC200, rx);
    spi.cs_n = 1'b0;
    for (int i = 0; i < 7; i++) begin
      spi.mosi = 16'h8255 >> (15 - i);
      cyc(2);
      spi.sclk = 1'b1;
      cyc(2);
      spi.sclk = 1'b0;
    end
    cyc(3);
    chk("miso_before_reset", {15'd0, spi.miso}, 16'd1);
    aresetn = 1'b0;
    #1;
    chk("miso_in_reset", {15'd0, spi.miso}, 16'd0);
    chk("cmd_word_in_reset", spi.cmd_word, 16'd0);
    cyc(2);
    spi.cs_n = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    cyc(2);
    aresetn = 1'b1;
    cyc(4);
    model_reset();
    send(16'hC200, rx);
    send(16'hC000, rx);
    send(16'hC000, rx);
    chk("reg2_after_reset", rx, 16'h0000);

    do_reset();
    for (int n = 0; n < 1025; n++) send(16'h0100, rx);
    send(16'hC000, rx);
    send(16'hC000, rx);
    chk("frame_cnt_wrap", rx, 16'h0400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
